// File: rtl/muldiv_if.sv
// Request/response bundle between the issue logic and the iterative RV32M multiply/divide unit.
// The master drives the request and operands; the slave returns busy, done and the result.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_data, rs2_data,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1_data, rs2_data,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide on operand magnitudes,
// one bit per cycle, with sign fix-up afterwards. Fixed 34-cycle start-to-done latency.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_reg;
    logic [4:0]      count_reg;
    logic [2:0]      op_reg;
    logic            sign_a_reg;
    logic            sign_b_reg;
    logic            div0_reg;
    logic [XLEN-1:0] a_orig_reg;
    logic [XLEN-1:0] a_mag_reg;
    logic [XLEN-1:0] b_mag_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] result_reg;

    // Operand preparation at capture time.
    logic            sign_a_in;
    logic            sign_b_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;

    always_comb begin
        sign_a_in = bus.rs1_data[XLEN-1] &
                    ((bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6));
        sign_b_in = bus.rs2_data[XLEN-1] &
                    ((bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6));
        mag_a_in  = sign_a_in ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
        mag_b_in  = sign_b_in ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
    end

    // One iteration step. hi/lo hold {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shift_rem;
    logic            div_ge;
    logic [XLEN-1:0] trial_rem;

    always_comb begin
        add_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_mag_reg} : {(XLEN+1){1'b0}});
        shift_rem = {hi_reg, lo_reg[XLEN-1]};
        div_ge    = (shift_rem >= {1'b0, b_mag_reg});
        // The true difference is below the divisor, so its low XLEN bits are exact.
        trial_rem = shift_rem[XLEN-1:0] - b_mag_reg;
    end

    // Sign fix-up and result selection, registered on the FIX->DONE edge.
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_next;

    always_comb begin
        product  = {hi_reg, lo_reg};
        prod_fix = (sign_a_reg ^ sign_b_reg) ? (~product + 1'b1) : product;
        quot_fix = (sign_a_reg ^ sign_b_reg) ? (~lo_reg + 1'b1) : lo_reg;
        rem_fix  = sign_a_reg ? (~hi_reg + 1'b1) : hi_reg;
        if (!op_reg[2]) begin
            result_next = (op_reg[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (div0_reg) begin
            result_next = op_reg[1] ? a_orig_reg : {XLEN{1'b1}};
        end else begin
            result_next = op_reg[1] ? rem_fix : quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            div0_reg   <= 1'b0;
            a_orig_reg <= '0;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        op_reg     <= bus.op;
                        sign_a_reg <= sign_a_in;
                        sign_b_reg <= sign_b_in;
                        div0_reg   <= (bus.rs2_data == '0);
                        a_orig_reg <= bus.rs1_data;
                        a_mag_reg  <= mag_a_in;
                        b_mag_reg  <= mag_b_in;
                        hi_reg     <= '0;
                        lo_reg     <= bus.op[2] ? mag_a_in : mag_b_in;
                        count_reg  <= '0;
                        state_reg  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (op_reg[2]) begin
                        if (div_ge) begin
                            hi_reg <= trial_rem;
                            lo_reg <= {lo_reg[XLEN-2:0], 1'b1};
                        end else begin
                            hi_reg <= shift_rem[XLEN-1:0];
                            lo_reg <= {lo_reg[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_reg <= add_sum[XLEN:1];
                        lo_reg <= {add_sum[0], lo_reg[XLEN-1:1]};
                    end
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_reg <= result_next;
                    state_reg  <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_reg == S_CALC) || (state_reg == S_FIX);
    assign bus.done   = (state_reg == S_DONE);
    assign bus.result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random vectors against a
// behavioural model, start-while-busy and mid-operation reset sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (o)
            3'd0: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; r = p[31:0]; end
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; r = p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'b0, b}; p = x * y; r = p[63:32]; end
            3'd3: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one operation and watch 40 cycles: latency, busy window, single done,
    // result hold afterwards. With noise set, start is pulsed at N+5, N+20 and N+34.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit noise, input string tag);
        int done_cnt   = 0;
        int first_done = -1;
        int busy_err   = 0;
        int hold_err   = 0;
        int both_err   = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.rs1_data = a;
        bus.rs2_data = b;
        sb_q.push_back(exp);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy !== (k <= 33)) busy_err++;
            if (bus.busy && bus.done) both_err++;
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
                if (sb_q.size() == 0) both_err++;
                else check({tag, " result"}, bus.result, sb_q.pop_front());
            end
            if (k >= 35 && bus.result !== exp) hold_err++;
            bus.start    = noise && (k == 5 || k == 20 || k == 34);
            bus.op       = 3'($urandom);
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(first_done), 32'd34);
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_window_errs"}, 32'(busy_err), 32'd0);
        check({tag, " result_hold_errs"}, 32'(hold_err), 32'd0);
        check({tag, " busy_done_overlap_or_underflow"}, 32'(both_err), 32'd0);
        check({tag, " scoreboard_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        $display("txn %s op=%0d a=0x%08h b=0x%08h exp=0x%08h result=0x%08h latency=%0d",
                 tag, o, a, b, exp, bus.result, first_done);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
        vecs[8]  = '{3'd4, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'h0000_1234, 32'd0,          32'h0000_1234};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB};
        vecs[13] = '{3'd5, 32'h0000_0055, 32'd0,          32'hFFFF_FFFF};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        repeat (3) @(negedge clk);
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset done",   32'(bus.done),   32'd0);
        check("reset result", bus.result,      32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (i % 3) == 0,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 3'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(o, a, b, ref_model(o, a, b), (i % 4) == 1, $sformatf("rnd%0d", i));
        end

        // Reset at N+10 aborts the operation; a new start at N+12 completes normally.
        begin
            int stray = 0;
            @(negedge clk);
            bus.start    = 1'b1;
            bus.op       = 3'd3;
            bus.rs1_data = 32'hFFFF_FFFF;
            bus.rs2_data = 32'hFFFF_FFFF;
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.done) stray++;
                if (k == 10) rst = 1'b1;
                if (k == 11) begin
                    check("midreset busy",   32'(bus.busy), 32'd0);
                    check("midreset done",   32'(bus.done), 32'd0);
                    check("midreset result", bus.result,    32'd0);
                    rst = 1'b0;
                end
            end
            check("midreset stray_done", 32'(stray), 32'd0);
            $display("txn midreset aborted op=3 stray_done=%0d", stray);
            run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "after_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
